// File: rtl/mac_address_table_if.sv
// Header-lookup request/response bundle between switch ports and the MAC table.
interface mac_address_table_if #(
  parameter int unsigned PORT_NUMBER = 4
);
  logic [PORT_NUMBER-1:0]                  request_valid;
  logic [PORT_NUMBER-1:0]                  request_ready;
  logic [PORT_NUMBER-1:0][47:0]            request_source_mac_address;
  logic [PORT_NUMBER-1:0][47:0]            request_destin_mac_address;
  logic [PORT_NUMBER-1:0]                  response_valid;
  logic [PORT_NUMBER-1:0][PORT_NUMBER-1:0] response_port_mask;
  logic [PORT_NUMBER-1:0]                  response_hit;

  modport master (
    output request_valid,
    output request_source_mac_address,
    output request_destin_mac_address,
    input  request_ready,
    input  response_valid,
    input  response_port_mask,
    input  response_hit
  );

  modport slave (
    input  request_valid,
    input  request_source_mac_address,
    input  request_destin_mac_address,
    output request_ready,
    output response_valid,
    output response_port_mask,
    output response_hit
  );
endinterface

// File: rtl/mac_address_table.sv
// MAC learning/forwarding table: round-robin lookup arbitration, source learning,
// destination resolution, aging and flush, with occupancy and drop statistics.
module mac_address_table #(
  parameter int unsigned PORT_NUMBER  = 4,
  parameter int unsigned ENTRY_NUMBER = 16,
  parameter int unsigned AGE_PERIOD   = 1000,
  parameter int unsigned AGE_LIMIT    = 255,
  localparam int unsigned COUNT_WIDTH = $clog2(ENTRY_NUMBER + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  mac_address_table_if.slave     bus,
  output logic [COUNT_WIDTH-1:0] entry_count,
  output logic [15:0]            learn_drop_count
);
  localparam int unsigned PORT_INDEX_WIDTH  = $clog2(PORT_NUMBER);
  localparam int unsigned ENTRY_INDEX_WIDTH = $clog2(ENTRY_NUMBER);
  localparam int unsigned TICK_WIDTH        = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  localparam int unsigned MAC_WIDTH         = 48;
  localparam int unsigned AGE_WIDTH         = 8;
  localparam int unsigned MULTICAST_BIT     = 40;

  typedef logic [PORT_NUMBER-1:0] port_mask_t;

  typedef struct packed {
    logic                        valid;
    logic [MAC_WIDTH-1:0]        mac;
    logic [PORT_INDEX_WIDTH-1:0] port;
    logic [AGE_WIDTH-1:0]        age;
  } entry_t;

  entry_t table_q [ENTRY_NUMBER];
  entry_t table_d [ENTRY_NUMBER];

  logic [PORT_INDEX_WIDTH-1:0]  pointer_q;
  logic [PORT_INDEX_WIDTH-1:0]  pointer_next;
  logic [TICK_WIDTH-1:0]        tick_count_q;
  logic                         tick;

  logic                         grant_found;
  logic [PORT_INDEX_WIDTH-1:0]  grant_port;
  port_mask_t                   grant_onehot;

  logic [MAC_WIDTH-1:0]         source_mac;
  logic [MAC_WIDTH-1:0]         destin_mac;
  logic                         source_hit;
  logic [ENTRY_INDEX_WIDTH-1:0] source_index;
  logic                         destin_hit;
  logic [PORT_INDEX_WIDTH-1:0]  destin_port;
  logic                         free_found;
  logic [ENTRY_INDEX_WIDTH-1:0] free_index;

  port_mask_t                   lookup_mask;
  logic                         lookup_hit;
  logic                         learn_request;
  logic                         learn_write;
  logic                         learn_drop;
  logic [ENTRY_INDEX_WIDTH-1:0] learn_index;
  logic [COUNT_WIDTH-1:0]       valid_total;

  port_mask_t                   response_valid_q;
  port_mask_t [PORT_NUMBER-1:0] response_mask_q;
  port_mask_t                   response_hit_q;

  // Round-robin grant: first valid port at or above the pointer, wrapping.
  always_comb begin
    int unsigned                 candidate;
    logic [PORT_INDEX_WIDTH-1:0] candidate_index;
    grant_found     = 1'b0;
    grant_port      = '0;
    candidate       = 0;
    candidate_index = '0;
    if (!reset && !flush) begin
      for (int unsigned i = 0; i < PORT_NUMBER; i++) begin
        candidate = 32'(pointer_q) + i;
        if (candidate >= PORT_NUMBER) candidate = candidate - PORT_NUMBER;
        candidate_index = PORT_INDEX_WIDTH'(candidate);
        if (!grant_found && bus.request_valid[candidate_index]) begin
          grant_found = 1'b1;
          grant_port  = candidate_index;
        end
      end
    end
  end

  assign grant_onehot      = grant_found ? (port_mask_t'(1) << grant_port) : '0;
  assign bus.request_ready = grant_onehot;
  assign pointer_next      = (32'(grant_port) == PORT_NUMBER - 1) ? '0
                                                                  : grant_port + PORT_INDEX_WIDTH'(1);
  assign tick              = (tick_count_q == TICK_WIDTH'(AGE_PERIOD - 1));

  // Search the pre-update table for source/destination matches and the first free slot.
  always_comb begin
    source_mac   = bus.request_source_mac_address[grant_port];
    destin_mac   = bus.request_destin_mac_address[grant_port];
    source_hit   = 1'b0;
    source_index = '0;
    destin_hit   = 1'b0;
    destin_port  = '0;
    free_found   = 1'b0;
    free_index   = '0;
    for (int unsigned e = 0; e < ENTRY_NUMBER; e++) begin
      if (table_q[e].valid && table_q[e].mac == source_mac) begin
        source_hit   = 1'b1;
        source_index = ENTRY_INDEX_WIDTH'(e);
      end
      if (table_q[e].valid && table_q[e].mac == destin_mac) begin
        destin_hit  = 1'b1;
        destin_port = table_q[e].port;
      end
      if (!table_q[e].valid && !free_found) begin
        free_found = 1'b1;
        free_index = ENTRY_INDEX_WIDTH'(e);
      end
    end
  end

  // Destination resolution: flood group/unknown, unicast to owner, filter own port.
  always_comb begin
    lookup_mask = ~(port_mask_t'(1) << grant_port);
    lookup_hit  = 1'b0;
    if (!destin_mac[MULTICAST_BIT] && destin_hit) begin
      lookup_hit  = 1'b1;
      lookup_mask = (destin_port == grant_port) ? '0 : (port_mask_t'(1) << destin_port);
    end
  end

  assign learn_request = grant_found && !source_mac[MULTICAST_BIT];
  assign learn_write   = learn_request && (source_hit || free_found);
  assign learn_drop    = learn_request && !source_hit && !free_found;
  assign learn_index   = source_hit ? source_index : free_index;

  // Next table state: aging, then learn/refresh (wins over aging), then flush (wins over all).
  always_comb begin
    valid_total = '0;
    for (int unsigned e = 0; e < ENTRY_NUMBER; e++) begin
      table_d[e] = table_q[e];
      if (tick && table_q[e].valid) begin
        table_d[e].age = table_q[e].age - AGE_WIDTH'(1);
        if (table_q[e].age == AGE_WIDTH'(1)) table_d[e].valid = 1'b0;
      end
      if (learn_write && learn_index == ENTRY_INDEX_WIDTH'(e)) begin
        table_d[e] = '{valid: 1'b1, mac: source_mac, port: grant_port,
                       age: AGE_WIDTH'(AGE_LIMIT)};
      end
      if (flush) table_d[e].valid = 1'b0;
      valid_total = valid_total + COUNT_WIDTH'(table_d[e].valid);
    end
  end

  // Table, arbiter pointer and aging tick counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned e = 0; e < ENTRY_NUMBER; e++) table_q[e] <= '0;
      pointer_q    <= '0;
      tick_count_q <= '0;
    end else begin
      for (int unsigned e = 0; e < ENTRY_NUMBER; e++) table_q[e] <= table_d[e];
      if (grant_found) pointer_q <= pointer_next;
      tick_count_q <= tick ? '0 : tick_count_q + TICK_WIDTH'(1);
    end
  end

  // Occupancy and saturating learn-drop statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_count      <= '0;
      learn_drop_count <= '0;
    end else begin
      entry_count <= valid_total;
      if (learn_drop && learn_drop_count != 16'hFFFF) begin
        learn_drop_count <= learn_drop_count + 16'd1;
      end
    end
  end

  // One-cycle response pulse to the port granted on the previous edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      response_valid_q <= '0;
      response_mask_q  <= '0;
      response_hit_q   <= '0;
    end else begin
      response_valid_q <= grant_onehot;
      response_mask_q  <= '0;
      response_hit_q   <= '0;
      if (grant_found) begin
        response_mask_q[grant_port] <= lookup_mask;
        response_hit_q[grant_port]  <= lookup_hit;
      end
    end
  end

  assign bus.response_valid     = response_valid_q;
  assign bus.response_port_mask = response_mask_q;
  assign bus.response_hit       = response_hit_q;
endmodule

// File: tb/tb_mac_address_table.sv
// Self-checking bench: directed scenarios plus random traffic against a map-based table model.
module tb_mac_address_table;
  localparam int unsigned P        = 4;
  localparam int unsigned E        = 16;
  localparam int unsigned A_PERIOD = 20;
  localparam int unsigned A_LIMIT  = 3;
  localparam int unsigned B_PERIOD = 4;
  localparam int unsigned B_LIMIT  = 2;

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MCAST = 48'h0100_5E00_0001;

  typedef logic [P-1:0][P-1:0] mask_array_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, flush_a, rst_b, flush_b;
  logic [4:0]  count_a, count_b;
  logic [15:0] drop_a, drop_b;

  mac_address_table_if #(.PORT_NUMBER(P)) bus_a ();
  mac_address_table_if #(.PORT_NUMBER(P)) bus_b ();

  mac_address_table #(.PORT_NUMBER(P), .ENTRY_NUMBER(E), .AGE_PERIOD(A_PERIOD), .AGE_LIMIT(A_LIMIT))
    dut_a (.clock(clk), .reset(rst_a), .flush(flush_a), .bus(bus_a),
           .entry_count(count_a), .learn_drop_count(drop_a));

  mac_address_table #(.PORT_NUMBER(P), .ENTRY_NUMBER(E), .AGE_PERIOD(B_PERIOD), .AGE_LIMIT(B_LIMIT))
    dut_b (.clock(clk), .reset(rst_b), .flush(flush_b), .bus(bus_b),
           .entry_count(count_b), .learn_drop_count(drop_b));

  // Stimulus state
  logic [P-1:0]       a_valid, b_valid;
  logic [P-1:0][47:0] a_src, a_dst, b_src, b_dst;
  logic               a_reset, a_flush, b_reset;
  logic [P-1:0]       last_ready_a;
  int                 b_cnt;

  // Reference model of instance a
  int unsigned m_port [bit [47:0]];
  int unsigned m_age  [bit [47:0]];
  int          m_ptr, m_tick, m_drop, last_grant;
  logic [P-1:0] exp_ready, exp_resp_valid, exp_hit;
  mask_array_t  exp_mask;
  int           exp_count;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [47:0] pool_mac(input int unsigned idx);
    return 48'h0200_0000_0000 | 48'(idx);
  endfunction

  function automatic logic [47:0] rand_mac();
    int unsigned r;
    r = $urandom_range(15);
    if (r == 0) return BCAST;
    if (r == 1) return MCAST | 48'($urandom_range(7));
    return pool_mac($urandom_range(47));
  endfunction

  // One clock of the model: arbitration, lookup and table update from the rules.
  task automatic model_cycle();
    int          g;
    bit          tick, learn, hit_pre;
    int unsigned size_pre;
    bit [47:0]   src, dst;
    bit [47:0]   keys [$];
    g = -1;
    exp_ready = '0;
    if (!a_reset && !a_flush) begin
      for (int i = 0; i < P; i++) begin
        int p;
        p = (m_ptr + i) % P;
        if (g < 0 && a_valid[p]) g = p;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    last_grant = g;
    exp_resp_valid = exp_ready;
    exp_mask = '0;
    exp_hit  = '0;
    if (a_reset) begin
      m_port.delete();
      m_age.delete();
      m_ptr = 0; m_tick = 0; m_drop = 0; exp_count = 0;
      exp_resp_valid = '0;
      return;
    end
    if (g >= 0) begin
      dst = a_dst[g];
      exp_mask[g] = ~(P'(1) << g);
      if (!dst[40] && m_port.exists(dst)) begin
        exp_hit[g]  = 1'b1;
        exp_mask[g] = (int'(m_port[dst]) == g) ? '0 : (P'(1) << m_port[dst]);
      end
      m_ptr = (g + 1) % P;
    end
    tick   = (m_tick == A_PERIOD - 1);
    m_tick = tick ? 0 : m_tick + 1;
    if (a_flush) begin
      m_port.delete();
      m_age.delete();
    end else begin
      src      = (g >= 0) ? a_src[g] : '0;
      learn    = (g >= 0) && !src[40];
      hit_pre  = learn && m_port.exists(src);
      size_pre = m_port.num();
      if (tick) begin
        foreach (m_age[k]) keys.push_back(k);
        foreach (keys[i]) begin
          m_age[keys[i]] = m_age[keys[i]] - 1;
          if (m_age[keys[i]] == 0) begin
            m_age.delete(keys[i]);
            m_port.delete(keys[i]);
          end
        end
      end
      if (learn) begin
        if (hit_pre || size_pre < E) begin
          m_port[src] = g;
          m_age[src]  = A_LIMIT;
        end else if (m_drop != 16'hFFFF) begin
          m_drop++;
        end
      end
    end
    exp_count = m_port.num();
  endtask

  // Apply inputs, check combinational ready, clock once, check registered outputs.
  task automatic step();
    logic [P-1:0] b_exp_ready;
    bus_a.request_valid              = a_valid;
    bus_a.request_source_mac_address = a_src;
    bus_a.request_destin_mac_address = a_dst;
    rst_a   = a_reset;
    flush_a = a_flush;
    bus_b.request_valid              = b_valid;
    bus_b.request_source_mac_address = b_src;
    bus_b.request_destin_mac_address = b_dst;
    rst_b   = b_reset;
    flush_b = 1'b0;
    #1;
    model_cycle();
    last_ready_a = bus_a.request_ready;
    check("a_ready", 64'(bus_a.request_ready), 64'(exp_ready));
    b_exp_ready = b_reset ? '0 : b_valid;
    check("b_ready", 64'(bus_b.request_ready), 64'(b_exp_ready));
    if (b_reset) b_cnt = 0;
    else         b_cnt = (b_cnt == B_PERIOD - 1) ? 0 : b_cnt + 1;
    @(posedge clk);
    #1;
    check("a_resp_valid", 64'(bus_a.response_valid), 64'(exp_resp_valid));
    check("a_resp_mask", 64'(bus_a.response_port_mask), 64'(exp_mask));
    check("a_resp_hit", 64'(bus_a.response_hit), 64'(exp_hit));
    check("a_entry_count", 64'(count_a), 64'(exp_count));
    check("a_drop_count", 64'(drop_a), 64'(m_drop));
  endtask

  task automatic send_a(input int port, input logic [47:0] src, input logic [47:0] dst);
    a_valid = '0;
    a_valid[port] = 1'b1;
    a_src[port] = src;
    a_dst[port] = dst;
    step();
    a_valid = '0;
  endtask

  task automatic send_b(input int port, input logic [47:0] src, input logic [47:0] dst);
    b_valid = '0;
    b_valid[port] = 1'b1;
    b_src[port] = src;
    b_dst[port] = dst;
    step();
    b_valid = '0;
  endtask

  initial begin
    logic [47:0] mac_a;
    a_valid = '1; a_src = '0; a_dst = '0; a_reset = 1'b1; a_flush = 1'b0;
    b_valid = '0; b_src = '0; b_dst = '0; b_reset = 1'b1;
    b_cnt = 0; m_ptr = 0; m_tick = 0; m_drop = 0; last_grant = -1; exp_count = 0;

    // Reset with requests pending: nothing granted, everything cleared
    step();
    step();
    check("rst_count", 64'(count_a), 64'd0);
    check("rst_resp_valid", 64'(bus_a.response_valid), 64'd0);
    check("rst_drop", 64'(drop_a), 64'd0);
    check("rst_b_count", 64'(count_b), 64'd0);
    a_valid = '0; a_reset = 1'b0; b_reset = 1'b0;

    // Basic learn / lookup scenarios
    send_a(1, 48'h0200_0000_0001, 48'h0200_0000_0009);
    check("p1_flood_valid", 64'(bus_a.response_valid), 64'b0010);
    check("p1_flood_mask", 64'(bus_a.response_port_mask[1]), 64'b1101);
    check("p1_flood_hit", 64'(bus_a.response_hit[1]), 64'd0);
    check("p1_learn_count", 64'(count_a), 64'd1);
    send_a(2, 48'h0200_0000_0002, 48'h0200_0000_0001);
    check("p2_unicast_mask", 64'(bus_a.response_port_mask[2]), 64'b0010);
    check("p2_unicast_hit", 64'(bus_a.response_hit[2]), 64'd1);
    send_a(1, 48'h0200_0000_0001, 48'h0200_0000_0001);
    check("p1_filter_mask", 64'(bus_a.response_port_mask[1]), 64'b0000);
    check("p1_filter_hit", 64'(bus_a.response_hit[1]), 64'd1);
    send_a(3, 48'h0200_0000_0003, BCAST);
    check("p3_bcast_mask", 64'(bus_a.response_port_mask[3]), 64'b0111);
    check("p3_bcast_hit", 64'(bus_a.response_hit[3]), 64'd0);

    // All ports requesting: strict rotation from pointer 0
    a_valid = '1;
    for (int p = 0; p < P; p++) begin
      a_src[p] = pool_mac(32'(4 + p));
      a_dst[p] = 48'h0200_0000_0001;
    end
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_grant", 64'(last_ready_a), 64'(1) << (i % 4));
      check("rr_resp", 64'(bus_a.response_valid), 64'(1) << (i % 4));
    end
    a_valid = '0;

    // Fill the table, overflow once, then move an entry to port 3
    a_flush = 1'b1;
    a_valid[0] = 1'b1;
    step();
    check("flush_ready", 64'(last_ready_a), 64'd0);
    check("flush_count", 64'(count_a), 64'd0);
    a_flush = 1'b0;
    a_valid = '0;
    for (int i = 0; i < 16; i++) send_a(0, 48'h0200_0000_1000 + 48'(i), MCAST);
    check("full_count", 64'(count_a), 64'd16);
    check("full_no_drop", 64'(drop_a), 64'd0);
    send_a(0, 48'h0200_0000_1010, MCAST);
    check("overflow_count", 64'(count_a), 64'd16);
    check("overflow_drop", 64'(drop_a), 64'd1);
    send_a(3, 48'h0200_0000_1000, MCAST);
    check("move_count", 64'(count_a), 64'd16);
    send_a(0, MCAST, 48'h0200_0000_1000);
    check("move_mask", 64'(bus_a.response_port_mask[0]), 64'b1000);
    check("move_hit", 64'(bus_a.response_hit[0]), 64'd1);

    // Flush with five entries present
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    for (int i = 0; i < 5; i++) send_a(i % 4, 48'h0200_0000_2000 + 48'(i), MCAST);
    check("five_count", 64'(count_a), 64'd5);
    a_flush = 1'b1;
    a_valid[2] = 1'b1;
    step();
    check("flush5_ready", 64'(last_ready_a), 64'd0);
    check("flush5_count", 64'(count_a), 64'd0);
    a_flush = 1'b0;
    a_valid = '0;

    // Aging on the small instance: idle entry expires
    mac_a = 48'h0200_0000_00AA;
    send_b(0, mac_a, MCAST);
    check("b_learn_count", 64'(count_b), 64'd1);
    for (int i = 0; i < 8; i++) step();
    check("b_aged_count", 64'(count_b), 64'd0);
    send_b(1, MCAST, mac_a);
    check("b_aged_mask", 64'(bus_b.response_port_mask[1]), 64'b1101);
    check("b_aged_hit", 64'(bus_b.response_hit[1]), 64'd0);

    // Aging: refresh on the tick that would expire the entry keeps it
    send_b(0, mac_a, MCAST);
    for (int i = 0; i < 8 && b_cnt != B_PERIOD - 1; i++) step();
    step();
    for (int i = 0; i < 8 && b_cnt != B_PERIOD - 1; i++) step();
    send_b(0, mac_a, MCAST);
    check("b_refresh_count", 64'(count_b), 64'd1);
    send_b(1, MCAST, mac_a);
    check("b_refresh_mask", 64'(bus_b.response_port_mask[1]), 64'b0001);
    check("b_refresh_hit", 64'(bus_b.response_hit[1]), 64'd1);

    // Random traffic with held requests, occasional flush, aging and overflow
    for (int n = 0; n < 2500; n++) begin
      for (int p = 0; p < P; p++) begin
        if (!a_valid[p] && $urandom_range(3) == 0) begin
          a_src[p]   = rand_mac();
          a_dst[p]   = rand_mac();
          a_valid[p] = 1'b1;
        end
      end
      a_flush = ($urandom_range(149) == 0);
      step();
      if (last_grant >= 0) a_valid[last_grant] = 1'b0;
    end
    a_flush = 1'b0;

    // Reset mid-stream: a request presented with reset gets no response
    a_valid = '0;
    a_valid[2] = 1'b1;
    a_src[2] = pool_mac(5);
    a_dst[2] = pool_mac(6);
    step();
    check("pre_rst_resp", 64'(bus_a.response_valid), 64'b0100);
    a_valid = '1;
    a_reset = 1'b1;
    step();
    check("mid_rst_ready", 64'(last_ready_a), 64'd0);
    check("mid_rst_resp", 64'(bus_a.response_valid), 64'd0);
    check("mid_rst_mask", 64'(bus_a.response_port_mask), 64'd0);
    check("mid_rst_count", 64'(count_a), 64'd0);
    check("mid_rst_drop", 64'(drop_a), 64'd0);
    a_reset = 1'b0;
    a_valid = '0;
    step();
    check("post_rst_resp", 64'(bus_a.response_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_address_table.md
Name: mac_address_table

Overview:
- Parametrised MAC learning and forwarding table for the multi-port switch fabric.
- Arbitrates header-lookup requests from PORT_NUMBER transceivers round-robin.
- Learns source MAC to ingress port and resolves destination MAC to an egress port mask (unicast, flood or filter).
- Ages out idle entries; provides flush and occupancy/drop statistics for the switch core.

Parameters:
PORT_NUMBER, 4, number of switch ports (>=2); PORT_INDEX_WIDTH = $clog2(PORT_NUMBER) derived
ENTRY_NUMBER, 16, table entries (>=2)
AGE_PERIOD, 1000, clock cycles per aging tick (>=1)
AGE_LIMIT, 255, ticks an entry survives without refresh (1..255, 8-bit age field)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
flush  input  1  invalidate all entries
request_valid  input  1 [PORT_NUMBER]  port p presents header
request_ready  output  1 [PORT_NUMBER]  request of port p accepted this cycle
request_source_mac_address  input  48 [PORT_NUMBER]  source MAC of port p frame
request_destin_mac_address  input  48 [PORT_NUMBER]  destination MAC of port p frame
response_valid  output  1 [PORT_NUMBER]  one-cycle result pulse for port p
response_port_mask  output  PORT_NUMBER [PORT_NUMBER]  egress ports for port p frame
response_hit  output  1 [PORT_NUMBER]  destination found as unicast entry
entry_count  output  $clog2(ENTRY_NUMBER+1)  valid entries
learn_drop_count  output  16  new source MACs not learned because table full

Behaviour:
- Reset (sync, has priority over all): every entry invalid; ages 0; tick counter 0; arbiter pointer 0; all request_ready, response_valid, response_port_mask, response_hit 0; entry_count 0; learn_drop_count 0.
- Arbitration:
  - request_ready is combinational: at most one bit high per cycle.
  - The granted port is the first port with request_valid high, searching from the pointer upward with wrap-around.
  - After a grant to port g, pointer becomes g+1 mod PORT_NUMBER. No grant leaves the pointer unchanged.
  - Throughput: 1 request per cycle. Requesters hold valid and data stable until ready.
  - request_ready is all 0 while flush or reset is high.
- Latency: request accepted at edge N, so response_valid[g] is high during cycle N+1 for exactly one cycle, with mask/hit. Other ports' response_valid are 0. No backpressure on responses.
- Lookup (evaluated on pre-update table state of the accept cycle):
  - Destination bit 40 set (multicast/broadcast, incl. FF:FF:FF:FF:FF:FF): mask = all ports except g; hit = 0.
  - Unicast match on valid entry with port q != g: mask = one-hot q; hit = 1.
  - Unicast match with q == g: mask = 0 (filter); hit = 1.
  - Miss: mask = all except g; hit = 0.
- Learn (written at accept edge):
  - Source bit 40 set: never learned, not counted.
  - Source matches valid entry: port := g, age := AGE_LIMIT.
  - Else: lowest-index invalid entry gets {mac, g, AGE_LIMIT}, valid := 1.
  - If full: no write; learn_drop_count += 1, saturating at 0xFFFF.
  - A frame whose src == dst in the same request sees the pre-learn table (miss -> flood).
- MAC uniqueness: a MAC is never held in two valid entries.
- Aging:
  - Tick counter counts 0..AGE_PERIOD-1; a tick occurs on the cycle the count equals AGE_PERIOD-1, then it wraps to 0.
  - On tick, every valid entry's age decrements. An entry whose age becomes 0 is invalidated.
  - The entry being learned/refreshed in the same cycle takes AGE_LIMIT instead (refresh wins).
- Flush: at the edge, all entries invalid. Flush overrides same-cycle learn and aging. The tick counter and learn_drop_count are unaffected. A response already in flight still issues, computed from the pre-flush table.
- entry_count: registered population of valid entries, consistent with the table after each edge.

Test Plan:
- Reset then port 1 sends src 02:00:00:00:00:01, dst 02:00:00:00:00:09 -> response_valid[1] next cycle, mask 4'b1101, hit 0, entry_count 1.
- Port 2 then sends dst 02:00:00:00:00:01 -> mask 4'b0010, hit 1. Port 1 sends same dst -> mask 4'b0000, hit 1. Dst FF:FF:FF:FF:FF:FF from port 3 -> mask 4'b0111, hit 0.
- All 4 ports hold valid for 8 cycles from pointer 0 -> grants 0,1,2,3,0,1,2,3, one per cycle, responses one cycle after each grant.
- Learn 16 distinct unicast sources, then a 17th -> entry_count 16, learn_drop_count 1; repeat of an existing source moved to port 3 -> lookup returns 4'b1000, count unchanged.
- AGE_PERIOD=4, AGE_LIMIT=2: learn entry, idle 8 cycles -> entry_count 0 and lookup floods. Refresh on the tick cycle -> entry survives.
- Assert flush with 5 entries -> entry_count 0 next cycle, ready low during flush. Assert reset mid-stream -> all outputs 0 the following cycle, and the in-flight response is suppressed.
